pipe_decoder: RTL and testbench

PIPE_DECODER -- requirements
Module: pipe_decoder

---
 rtl/decoder_pkg.sv | 64 ++++++
 rtl/decode_comb.sv | 93 +++++++++
 rtl/pipe_decoder.sv | 151 +++++++++++++++
 tb/tb_pipe_decoder.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared op codes, opcode bytes, ModRM sub-codes and types for pipe_decoder.
// Build option: PIPE_DECODER_SKID_EN selects the two-entry skid output stage.
package decoder_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NEG = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    localparam logic [7:0] OPC_LD   = 8'h8B;
    localparam logic [7:0] OPC_ST   = 8'h89;
    localparam logic [7:0] OPC_LIL  = 8'h66;
    localparam logic [7:0] OPC_ADD  = 8'h01;
    localparam logic [7:0] OPC_SUB  = 8'h29;
    localparam logic [7:0] OPC_CMP  = 8'h39;
    localparam logic [7:0] OPC_AND  = 8'h21;
    localparam logic [7:0] OPC_OR   = 8'h09;
    localparam logic [7:0] OPC_XOR  = 8'h31;
    localparam logic [7:0] OPC_JMP  = 8'h90;
    localparam logic [7:0] OPC_HLT  = 8'hF4;
    localparam logic [7:0] OPC_GRP1 = 8'h83;
    localparam logic [7:0] OPC_GRP3 = 8'hF7;
    localparam logic [7:0] OPC_GRP2 = 8'hC1;

    // ModRM reg sub-codes; group 2 shifts reuse the 100/101/111 slots
    localparam logic [2:0] RG_ADD = 3'b000;
    localparam logic [2:0] RG_OR  = 3'b001;
    localparam logic [2:0] RG_NOT = 3'b010;
    localparam logic [2:0] RG_NEG = 3'b011;
    localparam logic [2:0] RG_AND = 3'b100;
    localparam logic [2:0] RG_SUB = 3'b101;
    localparam logic [2:0] RG_XOR = 3'b110;
    localparam logic [2:0] RG_CMP = 3'b111;
    localparam logic [2:0] RG_SLL = 3'b100;
    localparam logic [2:0] RG_SRL = 3'b101;
    localparam logic [2:0] RG_SRA = 3'b111;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic       use_im;
        logic [2:0] rd;
        logic [2:0] rs;
        logic       is_ld;
        logic       is_st;
        logic       is_mov;
        logic       is_lil;
        logic       is_jmp;
        logic       is_hlt;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction-word to field decode for pipe_decoder.
// Build option: none (PIPE_DECODER_SKID_EN only affects the top).
module decode_comb
    import decoder_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [31:0]   ir,
    output dec_t          dec,
    output logic [DW-1:0] imm
);

    logic [7:0]  opc;
    logic [1:0]  md;
    logic [2:0]  rg;
    logic [2:0]  rm;
    logic [7:0]  imm8;
    logic [15:0] imm16;
    logic        bad;

    assign opc   = ir[31:24];
    assign md    = ir[23:22];
    assign rg    = ir[21:19];
    assign rm    = ir[18:16];
    assign imm8  = ir[15:8];
    assign imm16 = ir[15:0];

    always_comb begin
        dec    = '0;
        imm    = '0;
        bad    = 1'b0;
        dec.rd = rm;
        dec.rs = rg;
        unique case (opc)
            OPC_LD:  dec.is_ld = 1'b1;
            OPC_ST: begin
                if (md == 2'b11) dec.is_mov = 1'b1;
                else             dec.is_st  = 1'b1;
            end
            OPC_LIL: begin
                dec.is_lil = 1'b1;
                imm        = DW'(imm16);
            end
            OPC_ADD: dec.op = OP_ADD;
            OPC_SUB: dec.op = OP_SUB;
            OPC_CMP: dec.op = OP_CMP;
            OPC_AND: dec.op = OP_AND;
            OPC_OR:  dec.op = OP_OR;
            OPC_XOR: dec.op = OP_XOR;
            OPC_JMP: dec.is_jmp = 1'b1;
            OPC_HLT: dec.is_hlt = 1'b1;
            OPC_GRP1: begin
                dec.use_im = 1'b1;
                imm        = DW'($signed(imm8));
                case (rg)
                    RG_ADD:  dec.op = OP_ADD;
                    RG_OR:   dec.op = OP_OR;
                    RG_AND:  dec.op = OP_AND;
                    RG_SUB:  dec.op = OP_SUB;
                    RG_XOR:  dec.op = OP_XOR;
                    RG_CMP:  dec.op = OP_CMP;
                    default: bad    = 1'b1;
                endcase
            end
            OPC_GRP3: begin
                case (rg)
                    RG_NOT:  dec.op = OP_NOT;
                    RG_NEG:  dec.op = OP_NEG;
                    default: bad    = 1'b1;
                endcase
            end
            OPC_GRP2: begin
                dec.use_im = 1'b1;
                imm        = DW'(imm8);
                case (rg)
                    RG_SLL:  dec.op = OP_SLL;
                    RG_SRL:  dec.op = OP_SRL;
                    RG_SRA:  dec.op = OP_SRA;
                    default: bad    = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        // illegal words travel on as a plain flagged bubble
        if (bad) begin
            dec.op      = OP_ADD;
            dec.use_im  = 1'b0;
            imm         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_decoder.sv
// Pipelined decoder: handshake, RUN/HALTED control and output buffering.
// Build option: define PIPE_DECODER_SKID_EN for a registered-ready skid stage.
module pipe_decoder
    import decoder_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   ir,
    input  logic          resume,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    op,
    output logic          use_im,
    output logic [RW-1:0] rd,
    output logic [RW-1:0] rs,
    output logic [DW-1:0] imm,
    output logic          is_ld,
    output logic          is_st,
    output logic          is_mov,
    output logic          is_lil,
    output logic          is_jmp,
    output logic          is_hlt,
    output logic          illegal
);

    dec_t          dec;
    logic [DW-1:0] dec_imm;
    dec_t          out_q;
    logic [DW-1:0] imm_q;
    state_t        state;
    state_t        state_nxt;
    logic          in_fire;
    logic          out_fire;

    decode_comb #(
        .DW (DW)
    ) u_dec (
        .ir  (ir),
        .dec (dec),
        .imm (dec_imm)
    );

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // resume is only looked at once HALTED is already the current state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (in_fire && dec.is_hlt) state_nxt = ST_HALTED;
            end
            ST_HALTED: begin
                if (resume) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

`ifdef PIPE_DECODER_SKID_EN

    dec_t          skid_q;
    logic [DW-1:0] skid_imm;
    logic          skid_valid;
    logic          skid_valid_nxt;
    logic          ready_q;

    assign in_ready = ready_q && !rst;

    always_comb begin
        skid_valid_nxt = skid_valid;
        if (in_fire && out_valid && !out_ready) skid_valid_nxt = 1'b1;
        else if (out_fire)                      skid_valid_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_q      <= '0;
            imm_q      <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
            skid_imm   <= '0;
            ready_q    <= 1'b1;
        end else begin
            skid_valid <= skid_valid_nxt;
            ready_q    <= !skid_valid_nxt && (state_nxt == ST_RUN);
            if (in_fire && out_valid && !out_ready) begin
                skid_q   <= dec;
                skid_imm <= dec_imm;
            end
            if (!out_valid || out_ready) begin
                if (skid_valid) begin
                    out_q     <= skid_q;
                    imm_q     <= skid_imm;
                    out_valid <= 1'b1;
                end else if (in_fire) begin
                    out_q     <= dec;
                    imm_q     <= dec_imm;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

`else

    assign in_ready = !rst && (state == ST_RUN) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            imm_q     <= '0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_q     <= dec;
            imm_q     <= dec_imm;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`endif

    assign op      = out_q.op;
    assign use_im  = out_q.use_im;
    assign rd      = RW'(out_q.rd);
    assign rs      = RW'(out_q.rs);
    assign imm     = imm_q;
    assign is_ld   = out_q.is_ld;
    assign is_st   = out_q.is_st;
    assign is_mov  = out_q.is_mov;
    assign is_lil  = out_q.is_lil;
    assign is_jmp  = out_q.is_jmp;
    assign is_hlt  = out_q.is_hlt;
    assign illegal = out_q.illegal;

endmodule

// File: tb/tb_pipe_decoder.sv
// Self-checking bench for pipe_decoder: directed steps plus random traffic
// scored against a mnemonic-level reference model and a transfer queue.
module tb_pipe_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir;
    logic        resume;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  op;
    logic        use_im;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [31:0] imm;
    logic        is_ld, is_st, is_mov, is_lil, is_jmp, is_hlt, illegal;

    always #5 clk = ~clk;

    pipe_decoder #(
        .DW (32),
        .RW (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir        (ir),
        .resume    (resume),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op        (op),
        .use_im    (use_im),
        .rd        (rd),
        .rs        (rs),
        .imm       (imm),
        .is_ld     (is_ld),
        .is_st     (is_st),
        .is_mov    (is_mov),
        .is_lil    (is_lil),
        .is_jmp    (is_jmp),
        .is_hlt    (is_hlt),
        .illegal   (illegal)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic        use_im;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [31:0] imm;
        logic [6:0]  fl;
    } exp_t;

    typedef struct {
        exp_t e;
        int   cyc;
    } ent_t;

    ent_t q[$];
    int   vec = 0;
    int   errs = 0;
    int   cyc = 0;
    bit   halted_m = 0;
    bit   chk_lat = 0;
    bit   prev_stall = 0;
    bit   acc_g = 0;
    exp_t held;

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        vec++;
        assert (o === e) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Flags: {ld, st, mov, lil, jmp, hlt, illegal}
    function automatic exp_t ref_dec(logic [31:0] w);
        exp_t  e;
        string alus[11];
        string g83[8];
        string gf7[8];
        string gc1[8];
        string mn;
        string alu;
        logic [2:0] g;
        e = '0;
        e.rd = w[18:16];
        e.rs = w[21:19];
        g = w[21:19];
        alus = '{"ADD", "SUB", "CMP", "AND", "OR", "XOR",
                 "NEG", "NOT", "SLL", "SRL", "SRA"};
        g83 = '{"ADD", "OR", "", "", "AND", "SUB", "XOR", "CMP"};
        gf7 = '{"", "", "NOT", "NEG", "", "", "", ""};
        gc1 = '{"", "", "", "", "SLL", "SRL", "", "SRA"};
        mn = "ILL";
        alu = "";
        case (w[31:24])
            8'h8B: mn = "LD";
            8'h89: mn = (w[23:22] == 2'b11) ? "MOV" : "ST";
            8'h66: mn = "LIL";
            8'h90: mn = "JMP";
            8'hF4: mn = "HLT";
            8'h01: begin mn = "ALU"; alu = "ADD"; end
            8'h29: begin mn = "ALU"; alu = "SUB"; end
            8'h39: begin mn = "ALU"; alu = "CMP"; end
            8'h21: begin mn = "ALU"; alu = "AND"; end
            8'h09: begin mn = "ALU"; alu = "OR";  end
            8'h31: begin mn = "ALU"; alu = "XOR"; end
            8'h83: begin mn = "ALUS8"; alu = g83[g]; end
            8'hF7: begin mn = "ALU";   alu = gf7[g]; end
            8'hC1: begin mn = "ALUZ8"; alu = gc1[g]; end
            default: mn = "ILL";
        endcase
        if (mn.substr(0, 2) == "ALU" && alu == "") mn = "ILL";
        for (int i = 0; i < 11; i++)
            if (alus[i] == alu) e.op = 4'(i);
        case (mn)
            "LD":  e.fl = 7'b1000000;
            "ST":  e.fl = 7'b0100000;
            "MOV": e.fl = 7'b0010000;
            "LIL": begin e.fl = 7'b0001000; e.imm = {16'h0, w[15:0]}; end
            "JMP": e.fl = 7'b0000100;
            "HLT": e.fl = 7'b0000010;
            "ALUS8": begin
                e.use_im = 1'b1;
                e.imm = {{24{w[15]}}, w[15:8]};
            end
            "ALUZ8": begin
                e.use_im = 1'b1;
                e.imm = {24'h0, w[15:8]};
            end
            "ILL": begin e.fl = 7'b0000001; e.op = 4'h0; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t obs();
        return {op, use_im, rd, rs, imm,
                is_ld, is_st, is_mov, is_lil, is_jmp, is_hlt, illegal};
    endfunction

    function automatic logic [31:0] rand_ir(bit no_hlt);
        logic [7:0] opcs[16];
        logic [7:0] b;
        opcs = '{8'h8B, 8'h89, 8'h66, 8'h01, 8'h29, 8'h39, 8'h21, 8'h09,
                 8'h31, 8'h90, 8'hF4, 8'h83, 8'hF7, 8'hC1, 8'hFF, 8'h00};
        b = opcs[$urandom_range(0, 15)];
        if (b == 8'h00) b = 8'($urandom);
        if (no_hlt && b == 8'hF4) b = 8'h01;
        return {b, 24'($urandom)};
    endfunction

    // One clock: score the current cycle at negedge, then step past posedge
    task automatic tick();
        bit   inf;
        bit   outf;
        ent_t ent;
        @(negedge clk);
        inf = in_valid && in_ready;
        outf = out_valid && out_ready;
        acc_g = inf;
        if (rst) begin
            chk("rst_in_ready", 64'(in_ready), 64'(0));
            q.delete();
            halted_m = 0;
            prev_stall = 0;
        end else begin
            if (halted_m) chk("halt_in_ready", 64'(in_ready), 64'(0));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_hold", 64'(obs()), 64'(held));
            end
            if (outf) begin
                chk("out_avail", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    ent = q.pop_front();
                    chk("out", 64'(obs()), 64'(ent.e));
                    if (chk_lat)
                        chk("latency", 64'(cyc - ent.cyc), 64'(1));
                end
            end
            prev_stall = out_valid && !out_ready;
            held = obs();
            if (inf) begin
                ent.e = ref_dec(ir);
                ent.cyc = cyc;
                q.push_back(ent);
            end
            if (halted_m && resume) halted_m = 0;
            else if (!halted_m && inf && ir[31:24] == 8'hF4) halted_m = 1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(string tag, logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        ir = w;
        do begin
            tick();
            n++;
        end while (!acc_g && n < 20);
        chk({tag, "_accept"}, 64'(acc_g), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic expect_out(string tag, logic [3:0] eop, logic eui,
                              logic [31:0] eimm, logic [6:0] efl);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_op"}, 64'(op), 64'(eop));
        chk({tag, "_use_im"}, 64'(use_im), 64'(eui));
        chk({tag, "_imm"}, 64'(imm), 64'(eimm));
        chk({tag, "_flags"}, 64'({is_ld, is_st, is_mov, is_lil, is_jmp,
                                  is_hlt, illegal}), 64'(efl));
    endtask

    task automatic hold_halted(string tag, int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_blocked"}, 64'(acc_g), 64'(0));
        end
    endtask

    task automatic wait_accept(string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_g && n < 10);
        chk({tag, "_accept"}, 64'(acc_g), 64'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        ir = '0;
        resume = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_fields", 64'(obs()), 64'(0));

        chk_lat = 1;
        send("add_r", 32'h01C3_0000);
        expect_out("add_r", 4'h0, 1'b0, 32'h0, 7'b0);
        chk("add_r_rd", 64'(rd), 64'(3));
        chk("add_r_rs", 64'(rs), 64'(0));
        send("sub_i", 32'h83E8_FF00);
        expect_out("sub_i", 4'h1, 1'b1, 32'hFFFF_FFFF, 7'b0);
        send("sra_i", 32'hC1F8_0500);
        expect_out("sra_i", 4'hA, 1'b1, 32'h5, 7'b0);
        send("neg", 32'hF7D8_0000);
        expect_out("neg", 4'h6, 1'b0, 32'h0, 7'b0);
        send("st", 32'h8903_0000);
        expect_out("st", 4'h0, 1'b0, 32'h0, 7'b0100000);
        send("mov", 32'h89C3_0000);
        expect_out("mov", 4'h0, 1'b0, 32'h0, 7'b0010000);
        send("ill", 32'hFF00_0000);
        expect_out("ill", 4'h0, 1'b0, 32'h0, 7'b0000001);
        send("lil", 32'h6600_1234);
        expect_out("lil", 4'h0, 1'b0, 32'h1234, 7'b0001000);
        send("ill_sub", 32'h83D0_7F00);
        expect_out("ill_sub", 4'h0, 1'b0, 32'h0, 7'b0000001);

        send("hlt", 32'hF400_0000);
        expect_out("hlt", 4'h0, 1'b0, 32'h0, 7'b0000010);
        in_valid = 1'b1;
        ir = 32'h01C3_0000;
        hold_halted("hlt", 4);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        wait_accept("hlt_resume");
        expect_out("after_hlt", 4'h0, 1'b0, 32'h0, 7'b0);

        resume = 1'b1;
        send("hlt_res", 32'hF400_0000);
        resume = 1'b0;
        in_valid = 1'b1;
        ir = 32'h2911_0000;
        hold_halted("hlt_res", 3);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        wait_accept("hlt_res_resume");
        expect_out("after_hlt_res", 4'h1, 1'b0, 32'h0, 7'b0);
        tick();

        chk_lat = 0;
        in_valid = 1'b1;
        ir = rand_ir(1);
        for (int i = 0; i < 30; i++) begin
            out_ready = !(i >= 6 && i < 9) && !(i >= 15 && i < 18);
            tick();
            if (acc_g) ir = rand_ir(1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("stall_drain", 64'(q.size()), 64'(0));

        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc_g) begin
                in_valid = ($urandom_range(0, 3) != 0);
                ir = rand_ir(0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            resume = ($urandom_range(0, 7) == 0);
            tick();
        end
        resume = 1'b0;

        in_valid = 1'b1;
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_fields", 64'(obs()), 64'(0));

        chk_lat = 1;
        for (int i = 0; i < 60; i++) begin
            if (!in_valid || acc_g) begin
                in_valid = ($urandom_range(0, 4) != 0);
                ir = rand_ir(1);
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("final_drain", 64'(q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
